pll_cen_gen: RTL and testbench
==============================

// Module: pll_cen_gen
// PURPOSE
//  Multi-channel fractional clock-enable generator clocked by a PLL output clock. Produces
//  per-channel one-cycle enable pulses at rate num/den of refclk, with per-channel start
//  phase. Gates all enables on a synchronised PLL lock plus a settle period. Accepts
//  glitch-free runtime reconfiguration through a valid/ready port.
// PARAMETERS
//  CHANNELS   4     number of enable outputs (1..16)
//  ACC_W      24    width of num/den/phase and per-channel accumulator
//  SETTLE_CYC 1024  refclk cycles counted after lock before enables run (>=1)
// PORTS
//  refclk     in   1             system clock (PLL output); all logic on rising edge
//  rst        in   1             asynchronous, active-high reset
//  locked     in   1             PLL lock, asynchronous to refclk
//  cfg_valid  in   1             config request
//  cfg_ready  out  1             config slot free; transfer on cfg_valid & cfg_ready
//  cfg_ch     in   $clog2(CH)    target channel (>=CHANNELS: accepted, discarded)
//  cfg_num    in   ACC_W         rate numerator
//  cfg_den    in   ACC_W         rate denominator
//  cfg_phase  in   ACC_W         accumulator start value
//  cfg_done   out  1             one-cycle pulse when pending config is applied
//  ready      out  1             high while in RUN
//  cen        out  CHANNELS      registered enable pulses
// BEHAVIOUR
//  Reset (async): cen=0, ready=0, cfg_done=0, cfg_ready=1; all num/den/phase/acc=0
//   (all channels disabled); state WAIT_LOCK; sync flops 0.
//  locked passes a 2-FF synchroniser -> lk_s. FSM:
//   WAIT_LOCK: lk_s=1 -> SETTLE, counter:=0.
//   SETTLE: counter++ each cycle; lk_s=0 -> WAIT_LOCK; counter==SETTLE_CYC-1 -> RUN.
//   RUN: ready=1; lk_s=0 -> WAIT_LOCK (ready, cen low next edge).
//   Entering RUN: every acc := its phase. Outside RUN: cen=0, acc held at phase.
//  Channel step (each RUN edge): sum = acc + num in ACC_W+1 bits.
//   sum >= den: acc <= sum - den, cen[i] <= 1; else acc <= sum, cen[i] <= 0.
//   den==0 or num==0: channel idle, cen[i]=0 always.
//   num>=den: cen[i]=1 every RUN cycle.
//   phase>=den: load den-1 instead, so the first step always pulses.
//  Config: one shadow slot. Accept -> slot full, cfg_ready=0 next cycle.
//   Slot applied to channel cfg_ch on the first edge where:
//    (a) FSM not in RUN; (b) the target is idle; or (c) the target emits cen.
//   In case (c), that edge's cen=1 uses the old config; acc := new phase
//    (clamped), not sum-den. No pulse is shortened, doubled or dropped.
//   On apply: cfg_done=1 for one cycle; cfg_ready=1 on the next cycle.
//    Accept is therefore never same-cycle as apply.
//   Out-of-range cfg_ch: applied/discarded next edge with cfg_done pulse.
//  Lock loss with slot full: slot is applied by case (a) on the next edge.
//  rst mid-operation: everything returns to reset values at once; slot is emptied.
// STRUCTURE
//  pll_cen_pkg: run_state_t enum {WAIT_LOCK,SETTLE,RUN}; cen_cfg_t struct
//   {num,den,phase}; lock sync depth constant (2).
//  Sub-module pll_cen_acc: one channel (cfg regs, accumulator, compare, cen flop,
//   apply input). Top: synchroniser, FSM, settle counter, shadow slot, generate loop.
// TESTING
//  1 rst, locked=0 for 50 cycles -> ready=0, cen=0. Raise locked ->
//    ready=1 exactly 2+SETTLE_CYC+1 edges later.
//  2 ch0 num=1 den=4 phase=0 -> first cen[0] on 4th RUN edge, then period 4.
//    ch0 phase=3 -> first pulse on 1st RUN edge.
//  3 ch1 num=3 den=8 -> exactly 3 pulses per 8 cycles over 800 cycles, no two
//    adjacent. ch2 num=9 den=8 -> cen[2] constant 1.
//  4 RUN, ch1 den 4->6 mid-period -> cfg_ready low until next cen[1].
//    cfg_done coincides with that pulse; later periods are 6; no interval <4.
//  5 locked drop in RUN -> ready=0 and cen=0 within 3 edges. Relock ->
//    full settle, then phases restart from cfg_phase.
//  6 rst asserted mid-RUN with slot full -> cen/ready drop asynchronously.
//    After release cfg_ready=1 and all channels idle.

Source files
------------

// File: rtl/pll_cen_pkg.sv
// Shared types for the fractional clock-enable generator: run states, the
// per-channel configuration record and the lock synchroniser depth.
package pll_cen_pkg;

    localparam int LOCK_SYNC_DEPTH = 2;
    // Width of the configuration record; ACC_W of the generator must not exceed it.
    localparam int CFG_W = 24;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2
    } run_state_t;

    typedef struct packed {
        logic [CFG_W-1:0] num;
        logic [CFG_W-1:0] den;
        logic [CFG_W-1:0] phase;
    } cen_cfg_t;

    // A start phase at or above den is pulled down to den-1 so the first step pulses.
    function automatic logic [CFG_W-1:0] clamp_phase(input logic [CFG_W-1:0] den,
                                                     input logic [CFG_W-1:0] phase);
        if ((den != '0) && (phase >= den)) begin
            return den - 1'b1;
        end
        return phase;
    endfunction

endpackage

// File: rtl/pll_cen_acc.sv
// One enable channel: holds its num/den/phase, steps a modulo-den accumulator
// while running, and takes a new configuration when apply_i is asserted.
module pll_cen_acc
    import pll_cen_pkg::*;
#(
    parameter int ACC_W = CFG_W
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     run_i,
    input  logic     apply_i,
    input  cen_cfg_t cfg_i,
    output logic     fire_o,
    output logic     idle_o,
    output logic     cen_o
);

    logic [ACC_W-1:0] num_q, num_d;
    logic [ACC_W-1:0] den_q, den_d;
    logic [ACC_W-1:0] phase_q, phase_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] new_phase;
    logic [ACC_W:0]   sum;
    logic             cen_q;

    assign sum       = {1'b0, acc_q} + {1'b0, num_q};
    assign idle_o    = (num_q == '0) || (den_q == '0);
    assign fire_o    = run_i && !idle_o && (sum >= {1'b0, den_q});
    assign new_phase = ACC_W'(clamp_phase(cfg_i.den, cfg_i.phase));
    assign cen_o     = cen_q;

    // On apply the pulse of this edge still comes from the old settings;
    // the accumulator restarts from the new phase rather than sum-den.
    always_comb begin
        num_d   = num_q;
        den_d   = den_q;
        phase_d = phase_q;
        acc_d   = acc_q;
        if (apply_i) begin
            num_d   = cfg_i.num[ACC_W-1:0];
            den_d   = cfg_i.den[ACC_W-1:0];
            phase_d = new_phase;
            acc_d   = new_phase;
        end else if (!run_i) begin
            acc_d = phase_q;
        end else if (fire_o) begin
            acc_d = ACC_W'(sum - {1'b0, den_q});
        end else begin
            acc_d = sum[ACC_W-1:0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            num_q   <= '0;
            den_q   <= '0;
            phase_q <= '0;
            acc_q   <= '0;
            cen_q   <= 1'b0;
        end else begin
            num_q   <= num_d;
            den_q   <= den_d;
            phase_q <= phase_d;
            acc_q   <= acc_d;
            cen_q   <= fire_o;
        end
    end

endmodule

// File: rtl/pll_cen_gen.sv
// Multi-channel fractional clock-enable generator: lock synchroniser, run FSM
// with settle counter, single shadow configuration slot and per-channel steppers.
module pll_cen_gen
    import pll_cen_pkg::*;
#(
    parameter  int CHANNELS   = 4,
    parameter  int ACC_W      = 24,
    parameter  int SETTLE_CYC = 1024,
    localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                refclk,
    input  logic                rst,
    input  logic                locked,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [ACC_W-1:0]    cfg_num,
    input  logic [ACC_W-1:0]    cfg_den,
    input  logic [ACC_W-1:0]    cfg_phase,
    output logic                cfg_done,
    output logic                ready,
    output logic [CHANNELS-1:0] cen
);

    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    logic [LOCK_SYNC_DEPTH-1:0] lk_sync_q;
    logic                       lk_s;
    run_state_t                 state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       run_step;

    logic                       slot_full_q;
    cen_cfg_t                   slot_cfg_q;
    logic [CH_W-1:0]            slot_ch_q;
    logic                       cfg_done_q;
    logic                       tgt_ok;
    logic                       apply;
    logic [CHANNELS-1:0]        apply_ch;
    logic [CHANNELS-1:0]        fire;
    logic [CHANNELS-1:0]        idle;

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            lk_sync_q <= '0;
        end else begin
            lk_sync_q <= {lk_sync_q[LOCK_SYNC_DEPTH-2:0], locked};
        end
    end
    assign lk_s = lk_sync_q[LOCK_SYNC_DEPTH-1];

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            WAIT_LOCK: begin
                if (lk_s) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end
            end
            SETTLE: begin
                if (!lk_s) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (!lk_s) begin
                    state_d = WAIT_LOCK;
                end
            end
            default: state_d = WAIT_LOCK;
        endcase
    end

    // A lock loss seen in RUN already silences the channels on the exit edge.
    assign run_step = (state_q == RUN) && lk_s;
    assign ready    = (state_q == RUN);

    // Out-of-range targets keep tgt_ok high so they are discarded at once.
    always_comb begin
        tgt_ok = 1'b1;
        for (int i = 0; i < CHANNELS; i++) begin
            if (slot_ch_q == CH_W'(i)) begin
                tgt_ok = !run_step || idle[i] || fire[i];
            end
        end
    end
    assign apply     = slot_full_q && tgt_ok;
    assign cfg_ready = !slot_full_q;
    assign cfg_done  = cfg_done_q;

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            slot_full_q <= 1'b0;
            slot_cfg_q  <= '0;
            slot_ch_q   <= '0;
            cfg_done_q  <= 1'b0;
        end else begin
            cfg_done_q <= apply;
            if (apply) begin
                slot_full_q <= 1'b0;
            end else if (cfg_valid && !slot_full_q) begin
                slot_full_q      <= 1'b1;
                slot_ch_q        <= cfg_ch;
                slot_cfg_q.num   <= CFG_W'(cfg_num);
                slot_cfg_q.den   <= CFG_W'(cfg_den);
                slot_cfg_q.phase <= CFG_W'(cfg_phase);
            end
        end
    end

    genvar gi;
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
        assign apply_ch[gi] = apply && (slot_ch_q == CH_W'(gi));

        pll_cen_acc #(
            .ACC_W (ACC_W)
        ) u_acc (
            .clk_i   (refclk),
            .rst_i   (rst),
            .run_i   (run_step),
            .apply_i (apply_ch[gi]),
            .cfg_i   (slot_cfg_q),
            .fire_o  (fire[gi]),
            .idle_o  (idle[gi]),
            .cen_o   (cen[gi])
        );
    end

endmodule

// File: tb/tb_pll_cen_gen.sv
// Scoreboard bench: stimulus queues expected cen pulses, cfg_done pulses and
// ready transitions by edge number; a monitor pops and compares them.
module tb_pll_cen_gen;

    localparam int CH = 3;
    localparam int AW = 24;
    localparam int SC = 8;

    logic          refclk = 1'b0;
    logic          rst;
    logic          locked;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [1:0]    cfg_ch;
    logic [AW-1:0] cfg_num;
    logic [AW-1:0] cfg_den;
    logic [AW-1:0] cfg_phase;
    logic          cfg_done;
    logic          ready;
    logic [CH-1:0] cen;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;
    bit mon_on = 1'b0;
    logic mon_prev_rdy = 1'b0;

    typedef struct { int ch; int cyc; } cen_ev_t;
    typedef struct { logic val; int cyc; } rdy_ev_t;

    cen_ev_t cen_q[$];
    int      done_q[$];
    rdy_ev_t rdy_q[$];

    pll_cen_gen #(
        .CHANNELS   (CH),
        .ACC_W      (AW),
        .SETTLE_CYC (SC)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .locked    (locked),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_num   (cfg_num),
        .cfg_den   (cfg_den),
        .cfg_phase (cfg_phase),
        .cfg_done  (cfg_done),
        .ready     (ready),
        .cen       (cen)
    );

    always #5 refclk = ~refclk;

    initial forever begin
        @(posedge refclk);
        cyc = cyc + 1;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // Hand-derived pulse schedules; k counts RUN edges from 1.
    function automatic bit exp_pulse(input int ph, input int ch, input int k);
        bit r;
        r = 1'b0;
        if (ph == 0) begin
            if (ch == 0)      r = (k % 4 == 0);
            else if (ch == 1) r = (k % 8 == 0) || (k % 8 == 3) || (k % 8 == 6);
            else              r = 1'b1;
        end else if (ph == 1) begin
            if (ch == 0)      r = (k % 4 == 1);
            else if (ch == 1) r = (k <= 16) ? (k % 4 == 0) : ((k - 16) % 6 == 0);
            else              r = (k >= 19) && ((k - 19) % 4 == 0);
        end else begin
            if (ch == 0)      r = (k % 4 == 1);
            else if (ch == 1) r = (k % 6 == 0);
            else              r = (k % 4 == 1);
        end
        return r;
    endfunction

    task automatic push_win(input int ph, input int r, input int kmax);
        cen_ev_t e;
        for (int k = 1; k <= kmax; k++) begin
            for (int c = 0; c < CH; c++) begin
                if (exp_pulse(ph, c, k)) begin
                    e.ch  = c;
                    e.cyc = r + k;
                    cen_q.push_back(e);
                end
            end
        end
    endtask

    task automatic push_rdy(input logic v, input int c);
        rdy_ev_t e;
        e.val = v;
        e.cyc = c;
        rdy_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h want %0h at cyc %0d", name, act, exp, cyc);
        end
    endtask

    // Called just after a negedge with cfg_ready high; returns at the negedge
    // where cfg_ready is high again. dly = edges from transfer to apply.
    task automatic cfg_write(input int ch, input int num, input int den,
                             input int ph, input int dly);
        bit ok;
        cfg_valid = 1'b1;
        cfg_ch    = 2'(ch);
        cfg_num   = AW'(num);
        cfg_den   = AW'(den);
        cfg_phase = AW'(ph);
        done_q.push_back(cyc + 1 + dly);
        $display("cfg ch=%0d num=%0d den=%0d phase=%0d transfer at cyc %0d",
                 ch, num, den, ph, cyc + 1);
        @(negedge refclk);
        cfg_valid = 1'b0;
        chk("cfg_ready_busy", 32'(cfg_ready), 32'd0);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (cfg_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge refclk);
        end
        if (!ok) begin
            total = total + 1;
            bad   = bad + 1;
            $display("FAIL cfg_ready_timeout: got 0 want 1 after 100 cycles, ch=%0d", ch);
        end
    endtask

    initial begin
        cen_ev_t e;
        rdy_ev_t re;
        int      dc;
        wait (mon_on);
        forever begin
            @(negedge refclk);
            for (int c = 0; c < CH; c++) begin
                if (cen[c] === 1'b1) begin
                    total = total + 1;
                    if (cen_q.size() == 0) begin
                        bad = bad + 1;
                        $display("FAIL cen_unexpected: got pulse ch=%0d cyc=%0d want none", c, cyc);
                    end else begin
                        e = cen_q.pop_front();
                        if (e.ch != c || e.cyc != cyc) begin
                            bad = bad + 1;
                            $display("FAIL cen_pulse: got ch=%0d cyc=%0d want ch=%0d cyc=%0d",
                                     c, cyc, e.ch, e.cyc);
                        end
                    end
                end
            end
            if (cfg_done === 1'b1) begin
                total = total + 1;
                if (done_q.size() == 0) begin
                    bad = bad + 1;
                    $display("FAIL cfg_done_unexpected: got pulse cyc=%0d want none", cyc);
                end else begin
                    dc = done_q.pop_front();
                    $display("cfg_done at cyc %0d", cyc);
                    if (dc != cyc) begin
                        bad = bad + 1;
                        $display("FAIL cfg_done: got cyc=%0d want cyc=%0d", cyc, dc);
                    end
                end
            end
            if (ready !== mon_prev_rdy) begin
                total = total + 1;
                $display("ready -> %0b at cyc %0d", ready, cyc);
                if (rdy_q.size() == 0) begin
                    bad = bad + 1;
                    $display("FAIL ready_unexpected: got %0b at cyc=%0d want no change", ready, cyc);
                end else begin
                    re = rdy_q.pop_front();
                    if (re.val !== ready || re.cyc != cyc) begin
                        bad = bad + 1;
                        $display("FAIL ready_edge: got %0b cyc=%0d want %0b cyc=%0d",
                                 ready, cyc, re.val, re.cyc);
                    end
                end
            end
            mon_prev_rdy = ready;
        end
    end

    initial begin
        int r;
        rst       = 1'b1;
        locked    = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_num   = '0;
        cfg_den   = '0;
        cfg_phase = '0;
        repeat (3) @(negedge refclk);
        rst    = 1'b0;
        mon_on = 1'b1;
        @(negedge refclk);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_cen", 32'(cen), 32'd0);
        chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        chk("rst_cfg_done", 32'(cfg_done), 32'd0);

        // Configure while waiting for lock: applied on the next edge.
        cfg_write(0, 1, 4, 0, 1);
        cfg_write(1, 3, 8, 0, 1);
        cfg_write(2, 9, 8, 0, 1);
        cfg_write(3, 5, 5, 5, 1);
        while (cyc < 50) @(negedge refclk);
        chk("nolock_ready", 32'(ready), 32'd0);
        chk("nolock_cen", 32'(cen), 32'd0);

        locked = 1'b1;
        r = cyc + 2 + SC + 1;
        push_rdy(1'b1, r);
        push_win(0, r, 800);
        push_rdy(1'b0, r + 801);
        while (cyc < r + 798) @(negedge refclk);
        locked = 1'b0;
        while (cyc < r + 806) @(negedge refclk);
        chk("unlock_ready", 32'(ready), 32'd0);
        chk("unlock_cen", 32'(cen), 32'd0);

        cfg_write(0, 1, 4, 3, 1);
        cfg_write(1, 1, 4, 0, 1);
        cfg_write(2, 0, 8, 0, 1);
        locked = 1'b1;
        r = cyc + 2 + SC + 1;
        push_rdy(1'b1, r);
        push_win(1, r, 60);
        push_rdy(1'b0, r + 61);
        while (cyc < r + 12) @(negedge refclk);
        cfg_write(1, 1, 6, 0, 3);
        while (cyc < r + 16) @(negedge refclk);
        cfg_write(2, 1, 4, 9, 1);
        while (cyc < r + 58) @(negedge refclk);
        locked = 1'b0;
        while (cyc < r + 66) @(negedge refclk);

        // Relock with no reconfiguration: phases restart from stored values.
        locked = 1'b1;
        r = cyc + 2 + SC + 1;
        push_rdy(1'b1, r);
        push_win(2, r, 5);
        push_rdy(1'b0, r + 6);
        while (cyc < r + 3) @(negedge refclk);
        cfg_valid = 1'b1;
        cfg_ch    = 2'd1;
        cfg_num   = AW'(1);
        cfg_den   = AW'(6);
        cfg_phase = AW'(2);
        $display("cfg ch=1 num=1 den=6 phase=2 transfer at cyc %0d", cyc + 1);
        @(negedge refclk);
        cfg_valid = 1'b0;
        chk("slot_full", 32'(cfg_ready), 32'd0);
        @(negedge refclk);
        chk("pre_rst_cen", 32'(cen), 32'h5);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_cen", 32'(cen), 32'd0);
        chk("async_rst_ready", 32'(ready), 32'd0);
        chk("async_rst_cfg_ready", 32'(cfg_ready), 32'd1);
        chk("async_rst_cfg_done", 32'(cfg_done), 32'd0);
        repeat (3) @(negedge refclk);
        rst = 1'b0;
        r = cyc + 2 + SC + 1;
        push_rdy(1'b1, r);
        while (cyc < r + 30) @(negedge refclk);

        chk("cen_q_drained", 32'(cen_q.size()), 32'd0);
        chk("done_q_drained", 32'(done_q.size()), 32'd0);
        chk("rdy_q_drained", 32'(rdy_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
